// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame/baud constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // 50 MHz system clock divided down to 115200 baud
  localparam int CLKS_PER_BIT_115200_50MHZ = 434;

  // 8N1 frame: start + 8 data + stop
  localparam int FRAME_BITS = 10;

endpackage

// File: rtl/uart_sender_if.sv
// Handshake and line signals of the UART sender: start strobe, parallel
// word, ready flag and the serial TX output.
interface uart_sender_if #(
  parameter int WIDTH = 32
);

  logic             en;
  logic [WIDTH-1:0] data_in;
  logic             dout;
  logic             rdy;

  modport master (
    output en,
    output data_in,
    input  dout,
    input  rdy
  );

  modport slave (
    input  en,
    input  data_in,
    output dout,
    output rdy
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: emits a one-cycle tick every CLKS_PER_BIT clocks.
// A restart pulse realigns the period so a new frame starts on a clean
// boundary; kept separate so a receiver can reuse it.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200_50MHZ
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_restart,
  output logic o_bit_tick
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  // Count 0..CLKS_PER_BIT-1 and wrap; restart forces the count back to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_restart || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_bit_tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_sender.sv
// Serialises a WIDTH-bit word as WIDTH/8 back-to-back 8N1 frames,
// most-significant byte first, each byte LSB first. Pulse-start / ready
// handshake; the word is captured once and the inputs ignored while busy.
module uart_sender
  import uart_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200_50MHZ
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_sender_if.slave  bus
);

  localparam int            NBYTES    = WIDTH / 8;
  localparam int            BCW       = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(FRAME_BITS - 3);

  uart_state_e      r_state;
  logic [WIDTH-1:0] r_shift;
  logic [2:0]       r_bitIdx;
  logic [BCW-1:0]   r_byteCnt;
  logic             r_dout;
  logic             r_rdy;

  logic             w_start;
  logic             w_tick;
  logic [7:0]       w_curByte;
  logic [2:0]       w_nextIdx;

  assign w_start   = (r_state == IDLE) && bus.en;
  assign w_curByte = r_shift[WIDTH-1 -: 8];
  assign w_nextIdx = r_bitIdx + 3'd1;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_restart  (w_start),
    .o_bit_tick (w_tick)
  );

  // Frame sequencer; dout and rdy are registered so the TX pin never glitches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bitIdx  <= '0;
      r_byteCnt <= '0;
      r_dout    <= 1'b1;
      r_rdy     <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.en) begin
            r_shift   <= bus.data_in;
            r_bitIdx  <= '0;
            r_byteCnt <= '0;
            r_dout    <= 1'b0;
            r_rdy     <= 1'b0;
            r_state   <= START;
          end
        end
        START: begin
          if (w_tick) begin
            r_bitIdx <= '0;
            r_dout   <= w_curByte[0];
            r_state  <= DATA;
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_bitIdx == LAST_BIT) begin
              r_dout  <= 1'b1;
              r_state <= STOP;
            end else begin
              r_bitIdx <= w_nextIdx;
              r_dout   <= w_curByte[w_nextIdx];
            end
          end
        end
        STOP: begin
          if (w_tick) begin
            if (r_byteCnt == LAST_BYTE) begin
              r_dout  <= 1'b1;
              r_rdy   <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_byteCnt <= r_byteCnt + BCW'(1);
              r_shift   <= r_shift << 8;
              r_dout    <= 1'b0;
              r_state   <= START;
            end
          end
        end
        default: begin
          r_dout  <= 1'b1;
          r_rdy   <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.dout = r_dout;
  assign bus.rdy  = r_rdy;

endmodule

// File: tb/tb_uart_sender.sv
// Directed bench for uart_sender: one instance at the real 115200-baud
// divider for frame decoding and timing, one at 4 clocks/bit for the
// back-to-back case with en held high.
module tb_uart_sender;

  localparam int CPB_A = 434;
  localparam int CPB_B = 4;
  localparam int NB    = 321;

  logic clk = 1'b0;
  logic rstA_n;
  logic rstB_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_sender_if #(.WIDTH(32)) busA ();
  uart_sender_if #(.WIDTH(32)) busB ();

  uart_sender #(.WIDTH(32), .CLKS_PER_BIT(CPB_A)) dutA (
    .clk   (clk),
    .rst_n (rstA_n),
    .bus   (busA.slave)
  );

  uart_sender #(.WIDTH(32), .CLKS_PER_BIT(CPB_B)) dutB (
    .clk   (clk),
    .rst_n (rstB_n),
    .bus   (busB.slave)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle start strobe on instance A; returns just after the accepting edge
  task automatic applyStimulus(input logic [31:0] word);
    busA.data_in = word;
    busA.en      = 1'b1;
    @(posedge clk);
    #1;
    busA.en = 1'b0;
  endtask

  // Mid-bit sample of one frame starting at the current edge; returns one
  // cycle before the next frame boundary
  task automatic recvByteA(output logic [7:0] b, output logic s0, output logic s9);
    tick(CPB_A / 2);
    s0 = busA.dout;
    for (int i = 0; i < 8; i++) begin
      tick(CPB_A);
      b[i] = busA.dout;
    end
    tick(CPB_A);
    s9 = busA.dout;
    tick(CPB_A - CPB_A / 2 - 1);
  endtask

  task automatic recvWordA(input logic [31:0] expWord, input string tag);
    logic [7:0] b;
    logic       s0;
    logic       s9;
    for (int k = 0; k < 4; k++) begin
      recvByteA(b, s0, s9);
      checkOutput($sformatf("%s byte%0d", tag, k), {24'h0, b}, {24'h0, expWord[31 - 8*k -: 8]});
      checkOutput($sformatf("%s start%0d", tag, k), {31'h0, s0}, 32'h0);
      checkOutput($sformatf("%s stop%0d", tag, k), {31'h0, s9}, 32'h1);
      if (k == 3) checkOutput($sformatf("%s rdy last cycle", tag), {31'h0, busA.rdy}, 32'h0);
      tick(1);
    end
    checkOutput($sformatf("%s rdy at 17360", tag), {31'h0, busA.rdy}, 32'h1);
    checkOutput($sformatf("%s dout idle", tag), {31'h0, busA.dout}, 32'h1);
  endtask

  initial begin
    logic [7:0]    b2bBytes [4];
    logic [NB-1:0] obsV;
    logic [NB-1:0] expV;
    logic [7:0]    bb;
    logic          rdy159;
    logic          rdy160;
    logic          rdy161;
    int            idx;

    busA.en = 1'b0;  busA.data_in = '0;
    busB.en = 1'b0;  busB.data_in = '0;
    rstA_n  = 1'b0;  rstB_n = 1'b0;

    // Reset held for 3 cycles
    tick(3);
    checkOutput("reset dout", {31'h0, busA.dout}, 32'h1);
    checkOutput("reset rdy",  {31'h0, busA.rdy},  32'h1);
    rstA_n = 1'b1;
    rstB_n = 1'b1;

    // Idle with en low for 1000 cycles
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      checkOutput("idle dout", {31'h0, busA.dout}, 32'h1);
      checkOutput("idle rdy",  {31'h0, busA.rdy},  32'h1);
    end

    // Single word with ignored strobe and data change while busy
    $display("[TB] single word 51427963");
    applyStimulus(32'h51427963);
    checkOutput("accept rdy",  {31'h0, busA.rdy},  32'h0);
    checkOutput("accept dout", {31'h0, busA.dout}, 32'h0);
    fork
      recvWordA(32'h51427963, "word1");
      begin
        tick(1);
        busA.data_in = 32'h00000000;
        tick(4998);
        busA.en      = 1'b1;
        busA.data_in = 32'hFFFFFFFF;
        tick(1);
        busA.en      = 1'b0;
      end
    join

    // Reset during data bit 0 of byte 2
    $display("[TB] mid-frame reset");
    applyStimulus(32'h12345678);
    for (int k = 0; k < 2; k++) begin
      recvByteA(bb, rdy159, rdy160);
      checkOutput($sformatf("abort byte%0d", k), {24'h0, bb}, (k == 0) ? 32'h12 : 32'h34);
      tick(1);
    end
    tick(CPB_A + CPB_A / 2);
    checkOutput("pre-reset dout", {31'h0, busA.dout}, 32'h0);
    #2 rstA_n = 1'b0;
    #1;
    checkOutput("async reset dout", {31'h0, busA.dout}, 32'h1);
    checkOutput("async reset rdy",  {31'h0, busA.rdy},  32'h1);
    tick(2);
    rstA_n = 1'b1;
    tick(1);
    checkOutput("post-reset rdy", {31'h0, busA.rdy}, 32'h1);
    applyStimulus(32'hC33C0180);
    checkOutput("restart rdy", {31'h0, busA.rdy}, 32'h0);
    recvWordA(32'hC33C0180, "word3");

    // Back-to-back with en held high, 4 clocks per bit
    $display("[TB] back-to-back A5C30F81");
    b2bBytes[0] = 8'hA5; b2bBytes[1] = 8'hC3;
    b2bBytes[2] = 8'h0F; b2bBytes[3] = 8'h81;
    expV = '1;
    idx  = 0;
    for (int w = 0; w < 2; w++) begin
      for (int k = 0; k < 4; k++) begin
        for (int f = 0; f < 10; f++) begin
          for (int r = 0; r < CPB_B; r++) begin
            expV[idx] = (f == 0) ? 1'b0 : (f == 9) ? 1'b1 : b2bBytes[k][f-1];
            idx++;
          end
        end
      end
      if (w == 0) begin
        expV[idx] = 1'b1;
        idx++;
      end
    end
    busB.data_in = 32'hA5C30F81;
    busB.en      = 1'b1;
    tick(1);
    obsV    = '0;
    obsV[0] = busB.dout;
    rdy159  = 1'b0; rdy160 = 1'b0; rdy161 = 1'b0;
    for (int k = 1; k < NB; k++) begin
      tick(1);
      obsV[k] = busB.dout;
      if (k == 159) rdy159 = busB.rdy;
      if (k == 160) rdy160 = busB.rdy;
      if (k == 161) rdy161 = busB.rdy;
      if (k == NB - 1) busB.en = 1'b0;
    end
    checks++;
    assert (obsV === expV) else begin
      errors++;
      $error("[TB] FAIL b2b stream: observed %h expected %h", obsV, expV);
    end
    checkOutput("b2b rdy 159", {31'h0, rdy159}, 32'h0);
    checkOutput("b2b rdy 160", {31'h0, rdy160}, 32'h1);
    checkOutput("b2b rdy 161", {31'h0, rdy161}, 32'h0);
    tick(1);
    checkOutput("b2b rdy end", {31'h0, busB.rdy}, 32'h1);
    tick(2);
    checkOutput("b2b no restart", {31'h0, busB.rdy}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
